// File: rtl/unidade_controle_exp7.sv
// Moore sequencer for the exp7 memory game: drives datapath strobes from the state alone.
// One state per cycle; the only waits are on fimP, jogada_feita/fimT and iniciar.
module unidade_controle_exp7 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimRod,
    input  logic       fimT,
    input  logic       fimP,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       jogada_feita,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraP,
    output logic       contaP,
    output logic       zeraR,
    output logic       registraR,
    output logic       we,
    output logic       sinal_led,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL          = 4'h0,
        PREPARA          = 4'h1,
        MOSTRA_PRIMEIRA  = 4'h2,
        INICIO_RODADA    = 4'h3,
        ESPERA_JOGADA    = 4'h4,
        REGISTRA         = 4'h5,
        COMPARA          = 4'h6,
        PROXIMA_JOGADA   = 4'h7,
        PREPARA_ESCRITA  = 4'h8,
        ESPERA_ESCRITA   = 4'h9,
        REGISTRA_ESCRITA = 4'hA,
        ESCREVE          = 4'hB,
        PROXIMA_RODADA   = 4'hC,
        FIM_ACERTOU      = 4'hD,
        FIM_ERROU        = 4'hE,
        FIM_TIMEOUT      = 4'hF
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INICIAL:          state_next = iniciar ? PREPARA : INICIAL;
            PREPARA:          state_next = MOSTRA_PRIMEIRA;
            MOSTRA_PRIMEIRA:  state_next = fimP ? INICIO_RODADA : MOSTRA_PRIMEIRA;
            INICIO_RODADA:    state_next = ESPERA_JOGADA;
            // a play arriving together with the timer expiry still counts
            ESPERA_JOGADA:    state_next = jogada_feita ? REGISTRA :
                                           fimT ? FIM_TIMEOUT : ESPERA_JOGADA;
            REGISTRA:         state_next = COMPARA;
            COMPARA: begin
                if (!igual)                    state_next = FIM_ERROU;
                else if (!enderecoIgualRodada) state_next = PROXIMA_JOGADA;
                else if (fimRod)               state_next = FIM_ACERTOU;
                else                           state_next = PREPARA_ESCRITA;
            end
            PROXIMA_JOGADA:   state_next = ESPERA_JOGADA;
            PREPARA_ESCRITA:  state_next = ESPERA_ESCRITA;
            ESPERA_ESCRITA:   state_next = jogada_feita ? REGISTRA_ESCRITA :
                                           fimT ? FIM_TIMEOUT : ESPERA_ESCRITA;
            REGISTRA_ESCRITA: state_next = ESCREVE;
            ESCREVE:          state_next = PROXIMA_RODADA;
            PROXIMA_RODADA:   state_next = INICIO_RODADA;
            FIM_ACERTOU:      state_next = iniciar ? PREPARA : FIM_ACERTOU;
            FIM_ERROU:        state_next = iniciar ? PREPARA : FIM_ERROU;
            FIM_TIMEOUT:      state_next = iniciar ? PREPARA : FIM_TIMEOUT;
            default:          state_next = INICIAL;
        endcase
    end

    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraRod   = 1'b0;
        contaRod  = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraP     = 1'b0;
        contaP    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        we        = 1'b0;
        sinal_led = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        timeout   = 1'b0;
        case (state)
            PREPARA: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
                zeraP   = 1'b1;
            end
            MOSTRA_PRIMEIRA: begin
                sinal_led = 1'b1;
                contaP    = 1'b1;
            end
            INICIO_RODADA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA, ESPERA_ESCRITA: contaT = 1'b1;
            REGISTRA, REGISTRA_ESCRITA:    registraR = 1'b1;
            // advancing here makes the new play land at address rodada+1
            PROXIMA_JOGADA, PREPARA_ESCRITA: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            ESCREVE:        we = 1'b1;
            PROXIMA_RODADA: contaRod = 1'b1;
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = state;

endmodule
